// File: rtl/stack_pkg.sv
// stack_pkg: op and state encodings shared by the issuer and the pointer state machine.
package stack_pkg;

    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10
    } state_e;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/stack_op_issuer_if.sv
// stack_op_issuer_if: command/pointer link between the issuer and the pointer state machine.
interface stack_op_issuer_if;
    stack_pkg::op_e op;
    logic           ctl;
    logic [2:0]     ptr;
    modport master (output op, output ctl, input ptr);
    modport slave  (input op, input ctl, output ptr);
endinterface

// File: rtl/key_sync_edge.sv
// key_sync_edge: synchronizes an async key and emits a one-cycle pulse on its rising edge.
module key_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic key,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = (sync_q << 1) | SYNC_STAGES'(key);
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/stack_op_issuer.sv
// stack_op_issuer: turns push/pop key presses into one-shot commands for an external
// pointer state machine, tracking the stack contents and reporting errors.
module stack_op_issuer
    import stack_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 7
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               push_key,
    input  logic               pop_key,
    input  logic [3:0]         data_in,
    stack_op_issuer_if.master  bus,
    output logic [3:0]         top_data,
    output logic               full,
    output logic               empty,
    output logic               busy,
    output logic [3:0]         err_count
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          push_p, pop_p, over;
    logic [3:0]    rd;
    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic          ctl_q, ctl_d, busy_q, busy_d;
    logic [3:0]    top_q, top_d, err_q, err_d;
    logic [2:0]    exp_q, exp_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];

    key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_push (
        .clk(clk), .resetn(resetn), .key(push_key), .pulse(push_p)
    );
    key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pop (
        .clk(clk), .resetn(resetn), .key(pop_key), .pulse(pop_p)
    );

    assign full  = bus.ptr >= 3'(DEPTH);
    assign empty = bus.ptr == 3'd0;
    assign over  = bus.ptr > 3'(DEPTH);

    // New top is the entry just below the expected pointer; an empty stack reads 0.
    always_comb begin
        rd = '0;
        for (int i = 0; i < DEPTH; i++)
            if (exp_q == 3'(i + 1)) rd = mem_q[i];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ctl_d   = 1'b0;
        top_d   = top_q;
        err_d   = err_q;
        exp_d   = exp_q;
        tmr_d   = tmr_q;
        mem_d   = mem_q;
        case (state_q)
            S_IDLE: begin
                if (push_p) begin
                    if (full) begin
                        err_d = sat_inc(err_q);
                    end else begin
                        op_d    = OP_PUSH;
                        exp_d   = bus.ptr + 3'd1;
                        ctl_d   = 1'b1;
                        state_d = S_ISSUE;
                        for (int i = 0; i < DEPTH; i++)
                            if (bus.ptr == 3'(i)) mem_d[i] = data_in;
                    end
                end else if (pop_p) begin
                    if (empty || over) begin
                        err_d = sat_inc(err_q);
                    end else begin
                        op_d    = OP_POP;
                        exp_d   = bus.ptr - 3'd1;
                        ctl_d   = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                tmr_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.ptr == exp_q) begin
                    top_d   = rd;
                    state_d = S_IDLE;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    err_d   = sat_inc(err_q);
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            op_q    <= OP_PUSH;
            ctl_q   <= 1'b0;
            busy_q  <= 1'b0;
            top_q   <= '0;
            err_q   <= '0;
            exp_q   <= '0;
            tmr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctl_q   <= ctl_d;
            busy_q  <= busy_d;
            top_q   <= top_d;
            err_q   <= err_d;
            exp_q   <= exp_d;
            tmr_q   <= tmr_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.op    = op_q;
    assign bus.ctl   = ctl_q;
    assign top_data  = top_q;
    assign busy      = busy_q;
    assign err_count = err_q;
endmodule

// File: tb/tb_stack_op_issuer.sv
// tb_stack_op_issuer: directed key presses with a pointer-machine model; a forked
// monitor checks every ctl pulse against a queue of expected commands.
module tb_stack_op_issuer;
    import stack_pkg::*;

    localparam int TIMEOUT = 7;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       push_key = 1'b0;
    logic       pop_key = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic [3:0] top_data, err_count;
    logic       full, empty, busy;

    int         checks = 0;
    int         errors = 0;
    int         ctl_cnt = 0;
    logic [1:0] sb [$];

    stack_op_issuer_if bus ();

    stack_op_issuer #(.DEPTH(4), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .push_key(push_key), .pop_key(pop_key),
        .data_in(data_in), .bus(bus), .top_data(top_data), .full(full),
        .empty(empty), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic       prev = 1'b0;
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (bus.ctl === 1'b1) begin
                checks++;
                ctl_cnt++;
                if (sb.size() == 0 || prev) begin
                    errors++;
                    $display("FAIL ctl_unexpected: op %0d with no pending command", bus.op);
                end else begin
                    e = sb.pop_front();
                    if (bus.op !== e) begin
                        errors++;
                        $display("FAIL ctl_op: got %0d expected %0d", bus.op, e);
                    end
                end
            end
            prev = bus.ctl;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_op"}, 32'(bus.op), 0);
        chk({tag, "_ctl"}, 32'(bus.ctl), 0);
        chk({tag, "_top"}, 32'(top_data), 0);
        chk({tag, "_err"}, 32'(err_count), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #2 resetn = 1'b0;
        push_key = 1'b0;
        pop_key = 1'b0;
        bus.ptr = 3'd0;
        #1 check_reset_values("rst");
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Press keys, let the pointer model answer (or not), and time ctl and the return to idle.
    task automatic do_op(input logic psh, input logic pp, input logic [3:0] d,
                         input logic respond, input logic exp_ctl, input logic [1:0] exp_op);
        int   ctl_at = -1;
        int   idle_at = -1;
        logic busy_seen = 1'b0;
        if (exp_ctl) sb.push_back(exp_op);
        data_in = d;
        push_key = psh;
        pop_key = pp;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 4) begin
                push_key = 1'b0;
                pop_key = 1'b0;
            end
            if (busy) busy_seen = 1'b1;
            if (bus.ctl && ctl_at < 0) ctl_at = i;
            if (ctl_at >= 0 && idle_at < 0 && i > ctl_at && !busy) idle_at = i;
            if (respond && ctl_at >= 0 && i == ctl_at + 2)
                bus.ptr = (exp_op == OP_PUSH) ? 3'(bus.ptr + 3'd1) : 3'(bus.ptr - 3'd1);
        end
        chk("busy_seen", 32'(busy_seen), 32'(exp_ctl));
        if (exp_ctl) begin
            chk("ctl_latency", ctl_at, 2);
            chk("wait_len", idle_at - ctl_at, respond ? 3 : TIMEOUT + 1);
        end
        chk("busy_end", 32'(busy), 0);
    endtask

    initial begin
        int   base;
        logic seen;
        bus.ptr = 3'd0;
        fork
            monitor();
        join_none

        // push path
        reset_dut();
        do_op(1, 0, 4'd5, 1, 1, OP_PUSH);
        chk("push_top", 32'(top_data), 5);
        chk("push_err", 32'(err_count), 0);
        chk("push_empty", 32'(empty), 0);

        // pop on empty
        reset_dut();
        do_op(0, 1, 4'd0, 1, 0, OP_POP);
        chk("popempty_err", 32'(err_count), 1);
        chk("popempty_top", 32'(top_data), 0);

        // fill, reject push on full, then pop
        reset_dut();
        for (int v = 1; v <= 4; v++) do_op(1, 0, 4'(v), 1, 1, OP_PUSH);
        chk("fill_ptr", 32'(bus.ptr), 4);
        chk("fill_full", 32'(full), 1);
        chk("fill_top", 32'(top_data), 4);
        do_op(1, 0, 4'd9, 1, 0, OP_PUSH);
        chk("pushfull_err", 32'(err_count), 1);
        chk("pushfull_top", 32'(top_data), 4);
        do_op(0, 1, 4'd0, 1, 1, OP_POP);
        chk("pop_ptr", 32'(bus.ptr), 3);
        chk("pop_top", 32'(top_data), 3);
        chk("pop_full", 32'(full), 0);

        // simultaneous keys at ptr=2: push wins, pop silently dropped
        do_op(0, 1, 4'd0, 1, 1, OP_POP);
        chk("pop2_top", 32'(top_data), 2);
        do_op(1, 1, 4'd7, 1, 1, OP_PUSH);
        chk("both_ptr", 32'(bus.ptr), 3);
        chk("both_top", 32'(top_data), 7);
        chk("both_err", 32'(err_count), 1);

        // timeout: model never moves the pointer
        do_op(1, 0, 4'd8, 0, 1, OP_PUSH);
        chk("timeout_err", 32'(err_count), 2);
        chk("timeout_top", 32'(top_data), 7);
        chk("timeout_ptr", 32'(bus.ptr), 3);

        // out-of-range pointer rejects both operations
        bus.ptr = 3'd6;
        @(negedge clk);
        chk("over_full", 32'(full), 1);
        chk("over_empty", 32'(empty), 0);
        do_op(1, 0, 4'd1, 1, 0, OP_PUSH);
        chk("over_push_err", 32'(err_count), 3);
        do_op(0, 1, 4'd0, 1, 0, OP_POP);
        chk("over_pop_err", 32'(err_count), 4);

        // reset in the middle of WAIT
        bus.ptr = 3'd3;
        sb.push_back(OP_POP);
        pop_key = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.ctl;
        end
        chk("midwait_ctl_seen", 32'(seen), 1);
        repeat (2) @(negedge clk);
        chk("midwait_busy", 32'(busy), 1);
        chk("midwait_op", 32'(bus.op), 32'(OP_POP));
        #2 resetn = 1'b0;
        pop_key = 1'b0;
        #1 check_reset_values("midwait_rst");
        base = ctl_cnt;
        bus.ptr = 3'd0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        chk("midwait_no_ctl", ctl_cnt, base);
        chk("midwait_idle", 32'(busy), 0);
        chk("midwait_top", 32'(top_data), 0);

        // error counter saturation
        for (int n = 1; n <= 20; n++) begin
            do_op(0, 1, 4'd0, 1, 0, OP_POP);
            chk("sat_err", 32'(err_count), (n > 15) ? 15 : n);
        end

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stack_op_issuer.md
STACK_OP_ISSUER -- requirements
Module: stack_op_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 4; the stack capacity, so the pointer range is 0..DEPTH.
REQ-002 SHALL have parameter SYNC_STAGES, default 2; the number of key synchronizer flops.
REQ-003 SHALL have parameter TIMEOUT, default 7; the number of WAIT cycles before an operation is abandoned.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port push_key, input, 1 bit: raw push request, active-high, asynchronous to clk.
REQ-007 SHALL have port pop_key, input, 1 bit: raw pop request, active-high, asynchronous to clk.
REQ-008 SHALL have port data_in, input, 4 bits: value to push.
REQ-009 SHALL have port ptr, input, 3 bits: current stack pointer returned by the pointer state machine.
REQ-010 SHALL have port op, output, 2 bits: command to the pointer state machine; 00 = push, 01 = pop.
REQ-011 SHALL have port ctl, output, 1 bit: command strobe, high for exactly one cycle per issued command.
REQ-012 SHALL have port top_data, output, 4 bits: registered top-of-stack value.
REQ-013 SHALL have port full, output, 1 bit: high when ptr == DEPTH.
REQ-014 SHALL have port empty, output, 1 bit: high when ptr == 0.
REQ-015 SHALL have port busy, output, 1 bit: high while the FSM is not in IDLE.
REQ-016 SHALL have port err_count, output, 4 bits: saturating count of rejected or timed-out operations.

Function
REQ-017 SHALL synchronize each key through SYNC_STAGES flops and then rising-edge detect it, giving a one-cycle request pulse per key press.
REQ-018 SHALL implement FSM states IDLE, ISSUE and WAIT.
REQ-019 In IDLE, a push pulse SHALL take priority over a simultaneous pop pulse; the pop is dropped and not counted.
REQ-020 In IDLE, a push pulse with full=1, or a pop pulse with empty=1, SHALL increment err_count and remain in IDLE, with no ctl pulse.
REQ-021 In IDLE, an accepted push SHALL latch op=00, write data_in into mem[ptr], latch expected pointer ptr+1, and move to ISSUE.
REQ-022 In IDLE, an accepted pop SHALL latch op=01 and expected pointer ptr-1, and move to ISSUE.
REQ-023 ISSUE SHALL drive ctl=1 for one cycle with op stable, then move to WAIT.
REQ-024 op SHALL hold its value from ISSUE until the return to IDLE.
REQ-025 WAIT SHALL return to IDLE in the cycle ptr equals the expected pointer.
REQ-026 On that return, top_data SHALL load mem[expected-1], or 0 when expected == 0.
REQ-027 WAIT SHALL abandon after TIMEOUT cycles without a pointer match: increment err_count, return to IDLE, leave top_data unchanged.
REQ-028 Key pulses arriving while busy=1 SHALL be discarded and not counted.
REQ-029 err_count SHALL saturate at 15.
REQ-030 full and empty SHALL be combinational from ptr.
REQ-031 ptr values greater than DEPTH SHALL assert full, and both push and pop SHALL then be rejected.
REQ-032 Latency SHALL be as follows: a synchronized key edge detected in cycle N gives ctl=1 in cycle N+1.

Reset
REQ-033 resetn low SHALL immediately force: state IDLE, op=00, ctl=0, top_data=0, err_count=0, busy=0, synchronizers and edge registers 0.
REQ-034 Storage mem SHALL be cleared to 0 on reset.
REQ-035 Reset asserted mid-operation SHALL abort the operation with no ctl pulse afterward.

Structure
REQ-036 The op encodings (PUSH=00, POP=01), the state encodings and the default DEPTH SHALL live in shared package stack_pkg, also used by the pointer state machine.
REQ-037 The synchronizer plus edge detector SHALL be one sub-module, key_sync_edge, instantiated once per key.

Verification
REQ-038 A bench SHALL cover the push path: reset, ptr=0, data_in=5, push_key pulse -> one ctl pulse with op=00; model returns ptr=1; then top_data=5, busy=0.
REQ-039 A bench SHALL cover pop on empty: ptr=0, pop_key pulse -> no ctl, err_count=1, busy stays 0.
REQ-040 A bench SHALL cover push on full: push 4 values (1,2,3,4) -> ptr=4, full=1, top_data=4; a fifth push gives err_count+1 and no ctl; then pop -> op=01, ptr=3, top_data=3.
REQ-041 A bench SHALL cover simultaneous keys: push_key and pop_key rising in the same cycle, ptr=2 -> exactly one ctl with op=00.
REQ-042 A bench SHALL cover timeout: model holds ptr after ctl -> after 7 WAIT cycles FSM is IDLE, err_count+1, top_data unchanged.
REQ-043 A bench SHALL cover reset mid-WAIT and saturation: resetn low during WAIT -> all outputs at reset values and no stray ctl; 20 rejected pops -> err_count=15.
